// File: rtl/conv3x3_s2_rgb_merge_pkg.sv
// conv3x3_pkg: shared constants for the stride-2 3x3 RGB merge convolution.
// Holds the kernel coefficients, the output shift and the accumulator guard width.
package conv3x3_pkg;

  localparam int TAPS       = 9;
  localparam int SHIFT      = 4;
  localparam int GUARD_BITS = 6;

  // Index of a tap inside the 3x3 window: row * 3 + column, row 0 is the oldest row.
  typedef logic [3:0] tap_idx_t;

  // Smoothing kernel [1 2 1; 2 4 2; 1 2 1], shared by all three channels.
  localparam int K [0:TAPS-1] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  function automatic int kCoef(input tap_idx_t idx);
    return K[idx];
  endfunction

endpackage

// File: rtl/conv3x3_s2_rgb_merge_if.sv
// conv3x3_s2_rgb_merge_if: pixel-in / result-out bundle of the RGB merge convolution.
// master = pixel source side, slave = convolution block side.
interface conv3x3_s2_rgb_merge_if #(parameter int data_width = 32) ();

  logic                  valid_in_1;
  logic                  valid_in_2;
  logic                  valid_in_3;
  logic [data_width-1:0] pxl_in_1;
  logic [data_width-1:0] pxl_in_2;
  logic [data_width-1:0] pxl_in_3;
  logic [data_width-1:0] pxl_out;
  logic                  valid_out;

  modport master (
    output valid_in_1, valid_in_2, valid_in_3,
    output pxl_in_1, pxl_in_2, pxl_in_3,
    input  pxl_out, valid_out
  );

  modport slave (
    input  valid_in_1, valid_in_2, valid_in_3,
    input  pxl_in_1, pxl_in_2, pxl_in_3,
    output pxl_out, valid_out
  );

endinterface

// File: rtl/conv3x3_s2_rgb_merge_window.sv
// conv_window_3x3: two line buffers plus a 3x3 tap window for one raster-scanned channel.
// Everything advances only when shift_en_i is high; taps_o[row*3+col] with row 0 = oldest row.
module conv_window_3x3
  import conv3x3_pkg::*;
#(
  parameter int D          = 49,
  parameter int data_width = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            shift_en_i,
  input  logic [data_width-1:0]           pxl_i,
  output logic [TAPS-1:0][data_width-1:0] taps_o
);

  localparam int PW = $clog2(D);

  logic [data_width-1:0]           lineA_q [D];
  logic [data_width-1:0]           lineB_q [D];
  logic [PW-1:0]                   ptr_q;
  logic [TAPS-1:0][data_width-1:0] win_q;
  logic [2:0][data_width-1:0]      newCol;

  // Column entering the window: two rows up, one row up, current pixel.
  assign newCol[0] = lineB_q[ptr_q];
  assign newCol[1] = lineA_q[ptr_q];
  assign newCol[2] = pxl_i;

  // Circular line-buffer pointer; it tracks the column so slot ptr holds the pixel from one row earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (shift_en_i) begin
      if (ptr_q == PW'(D - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_q + PW'(1);
      end
    end
  end

  // Cascade the line buffers and slide the window one column left; stale contents are harmless after reset.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      lineA_q[ptr_q] <= pxl_i;
      lineB_q[ptr_q] <= lineA_q[ptr_q];
      for (int rr = 0; rr < 3; rr++) begin
        win_q[rr*3]     <= win_q[rr*3 + 1];
        win_q[rr*3 + 1] <= win_q[rr*3 + 2];
        win_q[rr*3 + 2] <= newCol[rr];
      end
    end
  end

  assign taps_o = win_q;

endmodule

// File: rtl/conv3x3_s2_rgb_merge.sv
// conv3x3_s2_rgb_merge: stride-2 3x3 convolution over R,G,B streams, summed into one output.
// Optional macro CONV_RELU_EN clamps negative merged results to zero.
// Result appears two clocks after the accept of the window's bottom-right pixel.
module conv3x3_s2_rgb_merge
  import conv3x3_pkg::*;
#(
  parameter int D          = 49,
  parameter int data_width = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  conv3x3_s2_rgb_merge_if.slave  bus
);

  localparam int CW    = $clog2(D);
  localparam int ACC_W = data_width + GUARD_BITS;

  logic                            accept;
  logic                            windowFire_d;
  logic                            windowFire_q;
  logic [CW-1:0]                   rowCnt_q;
  logic [CW-1:0]                   colCnt_q;
  logic [data_width-1:0]           pxlCh [3];
  logic [TAPS-1:0][data_width-1:0] tapsCh [3];
  logic signed [ACC_W-1:0]         chSum_d [3];
  logic signed [ACC_W-1:0]         chSum_q [3];
  logic                            s1Valid_q;
  logic signed [ACC_W-1:0]         acc;
  logic [data_width-1:0]           merged_d;
  logic [data_width-1:0]           pxlOut_q;
  logic                            validOut_q;
  logic                            unusedAccBits;

  assign accept = bus.valid_in_1 & bus.valid_in_2 & bus.valid_in_3;

  assign pxlCh[0] = bus.pxl_in_1;
  assign pxlCh[1] = bus.pxl_in_2;
  assign pxlCh[2] = bus.pxl_in_3;

  // A window completes on an even row and even column with at least two rows/cols behind it.
  assign windowFire_d = accept && (rowCnt_q >= CW'(2)) && (colCnt_q >= CW'(2))
                        && !rowCnt_q[0] && !colCnt_q[0];

  for (genvar ch = 0; ch < 3; ch++) begin : gChan
    conv_window_3x3 #(
      .D          (D),
      .data_width (data_width)
    ) uWin (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (accept),
      .pxl_i      (pxlCh[ch]),
      .taps_o     (tapsCh[ch])
    );
  end

  // Raster position of the next accepted pixel; wraps to (0,0) so frames run back-to-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowCnt_q <= '0;
      colCnt_q <= '0;
    end else if (accept) begin
      if (colCnt_q == CW'(D - 1)) begin
        colCnt_q <= '0;
        if (rowCnt_q == CW'(D - 1)) begin
          rowCnt_q <= '0;
        end else begin
          rowCnt_q <= rowCnt_q + CW'(1);
        end
      end else begin
        colCnt_q <= colCnt_q + CW'(1);
      end
    end
  end

  // Per-channel kernel sum, sign-extended into the guarded accumulator width.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      chSum_d[ch] = '0;
      for (int t = 0; t < TAPS; t++) begin
        chSum_d[ch] = chSum_d[ch]
                    + ACC_W'($signed(tapsCh[ch][t])) * ACC_W'(kCoef(tap_idx_t'(t)));
      end
    end
  end

  // Merge the channels; taking bits [data_width+SHIFT-1:SHIFT] equals an arithmetic shift then truncation.
  always_comb begin
    acc      = chSum_q[0] + chSum_q[1] + chSum_q[2];
    merged_d = acc[data_width+SHIFT-1:SHIFT];
`ifdef CONV_RELU_EN
    if (acc[ACC_W-1]) begin
      merged_d = '0;
    end
`endif
  end

  assign unusedAccBits = ^{acc[ACC_W-1:data_width+SHIFT], acc[SHIFT-1:0]};

  // Stage-1 channel sums are captured every cycle; only the valid flag decides whether they matter.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      chSum_q[ch] <= chSum_d[ch];
    end
  end

  // Valid pipeline and registered output; pxl_out holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      windowFire_q <= 1'b0;
      s1Valid_q    <= 1'b0;
      validOut_q   <= 1'b0;
      pxlOut_q     <= '0;
    end else begin
      windowFire_q <= windowFire_d;
      s1Valid_q    <= windowFire_q;
      validOut_q   <= s1Valid_q;
      if (s1Valid_q) begin
        pxlOut_q <= merged_d;
      end
    end
  end

  assign bus.pxl_out   = pxlOut_q;
  assign bus.valid_out = validOut_q;

endmodule

// File: tb/tb_conv3x3_s2_rgb_merge.sv
// tb_conv3x3_s2_rgb_merge: randomized and directed frames against a window-sum reference model.
module tb_conv3x3_s2_rgb_merge;

  localparam int D    = 49;
  localparam int DW   = 32;
  localparam int NPIX = D * D;
  localparam int NOUT = ((D - 3) / 2 + 1) * ((D - 3) / 2 + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  conv3x3_s2_rgb_merge_if #(.data_width(DW)) bus ();

  conv3x3_s2_rgb_merge #(
    .D          (D),
    .data_width (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;
  int outBase  = 0;

  int            pix [3][NPIX];
  logic [DW-1:0] gotVal [$];
  int            gotCyc [$];
  logic [DW-1:0] expVal [$];
  int            expCyc [$];

  logic [DW-1:0] prevOut;
  logic          prevReset = 1'b1;
  logic          monArmed  = 1'b0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Clock-edge counter used to timestamp accepts and outputs.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Output monitor: records each valid pulse and checks pxl_out holds while valid_out is low.
  always @(negedge clk) begin
    if (monArmed && !prevReset && !bus.valid_out) begin
      checkOutput("hold", 64'(bus.pxl_out), 64'(prevOut));
    end
    if (bus.valid_out) begin
      gotVal.push_back(bus.pxl_out);
      gotCyc.push_back(cycleCnt);
    end
    if (reset) monArmed = 1'b1;
    prevOut   = bus.pxl_out;
    prevReset = reset;
  end

  // Drives one cycle of inputs just after a rising edge.
  task automatic applyStimulus(input logic [2:0] valids, input logic [DW-1:0] p1,
                               input logic [DW-1:0] p2, input logic [DW-1:0] p3);
    @(posedge clk);
    #1;
    bus.valid_in_1 = valids[0];
    bus.valid_in_2 = valids[1];
    bus.valid_in_3 = valids[2];
    bus.pxl_in_1   = p1;
    bus.pxl_in_2   = p2;
    bus.pxl_in_3   = p3;
  endtask

  // Reference: every stride-2 window of the current frame, kernel weights from the 1-2-1 outer product.
  task automatic buildExpect();
    for (int r = 0; r + 2 < D; r += 2) begin
      for (int c = 0; c + 2 < D; c += 2) begin
        longint        acc;
        longint        sh;
        logic [63:0]   shBits;
        logic [DW-1:0] v;
        acc = 0;
        for (int ch = 0; ch < 3; ch++)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += longint'((i == 1 ? 2 : 1) * (j == 1 ? 2 : 1)) * longint'(pix[ch][(r+i)*D + c + j]);
        sh     = acc >>> 4;
        shBits = sh;
        v      = shBits[DW-1:0];
`ifdef CONV_RELU_EN
        if (acc < 0) v = '0;
`endif
        expVal.push_back(v);
      end
    end
  endtask

  // Streams npix pixels of the frame; gapMode 1 = 5 idle cycles before gapAt, 2 = random partial-valid bubbles.
  task automatic driveFrame(input int gapMode, input int gapAt, input int npix, input bit withExpect);
    if (withExpect) buildExpect();
    for (int idx = 0; idx < npix; idx++) begin
      if (gapMode == 1 && idx == gapAt) begin
        repeat (5) applyStimulus(3'b000, '0, '0, '0);
      end
      if (gapMode == 2) begin
        for (int b = 0; b < 3 && $urandom_range(0, 3) == 0; b++)
          applyStimulus(3'($urandom_range(0, 6)), $urandom, $urandom, $urandom);
      end
      applyStimulus(3'b111, pix[0][idx], pix[1][idx], pix[2][idx]);
      if (withExpect && (idx / D) >= 2 && (idx % D) >= 2 && (idx / D) % 2 == 0 && (idx % D) % 2 == 0)
        expCyc.push_back(cycleCnt + 3);
    end
  endtask

  task automatic newTest();
    outBase = gotVal.size();
    expVal.delete();
    expCyc.delete();
  endtask

  // Drains the pipeline, then compares count, values and timing against the model.
  task automatic checkAll(input string tag, input int frames);
    int n;
    repeat (6) applyStimulus(3'b000, '0, '0, '0);
    n = gotVal.size() - outBase;
    checkOutput({tag, "_count"}, 64'(n), 64'(expVal.size()));
    checkOutput({tag, "_nout"}, 64'(n), 64'(NOUT * frames));
    for (int k = 0; k < expVal.size() && k < n; k++) begin
      checkOutput($sformatf("%s_val[%0d]", tag, k), 64'(gotVal[outBase + k]), 64'(expVal[k]));
      checkOutput($sformatf("%s_cyc[%0d]", tag, k), 64'(gotCyc[outBase + k]), 64'(expCyc[k]));
    end
  endtask

  task automatic doReset(input int cycles, input string tag);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.valid_in_1 = 1'b0;
    bus.valid_in_2 = 1'b0;
    bus.valid_in_3 = 1'b0;
    repeat (cycles - 1) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(bus.valid_out), 64'(0));
    checkOutput({tag, "_pxl"}, 64'(bus.pxl_out), 64'(0));
  endtask

  task automatic fillConst(input int v);
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < NPIX; i++) pix[ch][i] = v;
  endtask

  task automatic fillRamp();
    for (int i = 0; i < NPIX; i++) begin
      pix[0][i] = i;
      pix[1][i] = 0;
      pix[2][i] = 0;
    end
  endtask

  task automatic fillRandom();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < NPIX; i++) pix[ch][i] = int'($urandom);
  endtask

  initial begin
    bus.valid_in_1 = 1'b0;
    bus.valid_in_2 = 1'b0;
    bus.valid_in_3 = 1'b0;
    bus.pxl_in_1   = '0;
    bus.pxl_in_2   = '0;
    bus.pxl_in_3   = '0;
    doReset(3, "rst");

    $display("[TB] constant 1 on all channels");
    fillConst(1);
    newTest();
    driveFrame(0, 0, NPIX, 1'b1);
    checkAll("const1", 1);
    checkOutput("const1_first", 64'(gotVal[outBase]), 64'(3));

    $display("[TB] ramp on channel 1");
    fillRamp();
    newTest();
    driveFrame(0, 0, NPIX, 1'b1);
    checkAll("ramp", 1);
    checkOutput("ramp_first", 64'(gotVal[outBase]), 64'(50));
    checkOutput("ramp_second", 64'(gotVal[outBase + 1]), 64'(52));
    checkOutput("ramp_last", 64'(gotVal[outBase + NOUT - 1]), 64'(47 * 49 + 47));

    $display("[TB] ramp with 5-cycle mid-row gap");
    newTest();
    driveFrame(1, 5 * D + 17, NPIX, 1'b1);
    checkAll("rampgap", 1);
    checkOutput("rampgap_first", 64'(gotVal[outBase]), 64'(50));

    $display("[TB] constant -1 on all channels");
    fillConst(-1);
    newTest();
    driveFrame(0, 0, NPIX, 1'b1);
    checkAll("neg1", 1);
`ifdef CONV_RELU_EN
    checkOutput("neg1_first", 64'(gotVal[outBase]), 64'(0));
`else
    checkOutput("neg1_first", 64'(gotVal[outBase]), 64'(32'hFFFF_FFFD));
`endif

    $display("[TB] random pixels with partial-valid bubbles");
    fillRandom();
    newTest();
    driveFrame(2, 0, NPIX, 1'b1);
    checkAll("randgap", 1);

    $display("[TB] reset in the middle of a frame");
    fillRandom();
    driveFrame(0, 0, 1000, 1'b0);
    doReset(1, "midrst");
    fillRandom();
    newTest();
    driveFrame(0, 0, NPIX, 1'b1);
    checkAll("afterrst", 1);

    $display("[TB] two back-to-back frames");
    fillRandom();
    newTest();
    driveFrame(0, 0, NPIX, 1'b1);
    driveFrame(0, 0, NPIX, 1'b1);
    checkAll("b2b", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
